// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline. It decides freeze, bubble,
// redirect or normal flow each cycle and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_MemRead,
  input  logic                 ex_redirect,
  input  logic                 mem_busy,
  input  logic                 cnt_clr,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_NORMAL,
    ACT_FREEZE,
    ACT_BUBBLE,
    ACT_REDIRECT
  } action_t;

  state_t  state_reg, state_next;
  logic    redirect_pend_reg, redirect_pend_next;
  action_t action;
  logic    rs1_match, rs2_match, hazard;
  logic    eff_redirect;
  logic [4:0] ctl;
  logic [1:0] cnt_inc;
  logic [1:0][CNT_WIDTH-1:0] cnt_q;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
  assign hazard    = ex_MemRead && (ex_rd != 5'd0) && (rs1_match || rs2_match);

  // A redirect seen while frozen is replayed once, merged with a live one.
  assign eff_redirect = ex_redirect || ((state_reg == MEM_WAIT) && redirect_pend_reg);

  always_comb begin
    state_next         = state_reg;
    redirect_pend_next = 1'b0;
    action             = ACT_NORMAL;
    case (state_reg)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          action             = ACT_FREEZE;
          state_next         = MEM_WAIT;
          redirect_pend_next = eff_redirect;
        end else if (eff_redirect) begin
          action     = ACT_REDIRECT;
          state_next = RUN;
        end else if (hazard) begin
          action     = ACT_BUBBLE;
          state_next = LU_STALL;
        end else begin
          action     = ACT_NORMAL;
          state_next = RUN;
        end
      end
      LU_STALL: begin
        // The bubble already resolved the load-use dependency; no re-check.
        if (mem_busy) begin
          action             = ACT_FREEZE;
          state_next         = MEM_WAIT;
          redirect_pend_next = ex_redirect;
        end else if (ex_redirect) begin
          action     = ACT_REDIRECT;
          state_next = RUN;
        end else begin
          action     = ACT_NORMAL;
          state_next = RUN;
        end
      end
      default: begin
        action     = ACT_NORMAL;
        state_next = RUN;
      end
    endcase
  end

  // ctl = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush}
  always_comb begin
    ctl = 5'b11100;
    case (action)
      ACT_FREEZE:   ctl = 5'b00000;
      ACT_BUBBLE:   ctl = 5'b00101;
      ACT_REDIRECT: ctl = 5'b11111;
      default:      ctl = 5'b11100;
    endcase
  end

  assign pc_en      = ctl[4] && !reset;
  assign ifid_en    = ctl[3] && !reset;
  assign idex_en    = ctl[2] && !reset;
  assign ifid_flush = ctl[1] && !reset;
  assign idex_flush = ctl[0] && !reset;
  assign state      = state_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= RUN;
      redirect_pend_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      redirect_pend_reg <= redirect_pend_next;
    end
  end

  // Index 0 counts cycles with the PC held, index 1 counts redirect flushes.
  assign cnt_inc[0] = (action == ACT_FREEZE) || (action == ACT_BUBBLE);
  assign cnt_inc[1] = (action == ACT_REDIRECT);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (cnt_clr) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_WIDTH{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign stall_cnt = cnt_q[0];
  assign flush_cnt = cnt_q[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: a 32-bit and a 4-bit counter instance share stimulus and
// are checked against a cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 0, id_uses_rs2 = 0, ex_MemRead = 0;
  logic       ex_redirect = 0, mem_busy = 0, cnt_clr = 0;

  logic        pc_en, ifid_en, idex_en, ifid_flush, idex_flush;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;
  logic        pc_en4, ifid_en4, idex_en4, ifid_flush4, idex_flush4;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  pipeline_hazard_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4),
    .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .state(state4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  typedef struct {
    int          tag;
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [31:0] s32, f32;
    logic [3:0]  s4, f4;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: mode 0=RUN 1=LU_STALL 2=MEM_WAIT, counters as integers.
  int     m_mode = 0;
  bit     m_pend = 0;
  longint m_s32 = 0, m_f32 = 0, m_s4 = 0, m_f4 = 0;

  function automatic longint sat_inc(input longint v, input longint maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic step(input int tag, input bit rst_i, input bit busy, input bit redir,
                      input bit mr, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input bit u1, input bit u2, input bit clr);
    exp_t e;
    int   act;
    bit   hz, eff;
    @(posedge clk);
    #1;
    reset = rst_i; mem_busy = busy; ex_redirect = redir; ex_MemRead = mr;
    ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    cnt_clr = clr;
    e.tag = tag;
    if (rst_i) begin
      m_mode = 0; m_pend = 0; m_s32 = 0; m_f32 = 0; m_s4 = 0; m_f4 = 0;
      e.st = 2'd0; e.ctl = 5'b00000;
      e.s32 = '0; e.f32 = '0; e.s4 = '0; e.f4 = '0;
    end else begin
      e.st  = m_mode[1:0];
      e.s32 = m_s32[31:0]; e.f32 = m_f32[31:0];
      e.s4  = m_s4[3:0];   e.f4  = m_f4[3:0];
      hz  = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
      eff = redir || (m_mode == 2 && m_pend);
      if (busy) begin
        act = 1; m_pend = eff; m_mode = 2;
      end else if (eff) begin
        act = 3; m_pend = 0; m_mode = 0;
      end else if (hz && m_mode != 1) begin
        act = 2; m_pend = 0; m_mode = 1;
      end else begin
        act = 0; m_pend = 0; m_mode = 0;
      end
      case (act)
        1:       e.ctl = 5'b00000;
        2:       e.ctl = 5'b00101;
        3:       e.ctl = 5'b11111;
        default: e.ctl = 5'b11100;
      endcase
      if (clr) begin
        m_s32 = 0; m_f32 = 0; m_s4 = 0; m_f4 = 0;
      end else begin
        if (act == 1 || act == 2) begin
          m_s32 = sat_inc(m_s32, 64'hFFFF_FFFF);
          m_s4  = sat_inc(m_s4, 15);
        end
        if (act == 3) begin
          m_f32 = sat_inc(m_f32, 64'hFFFF_FFFF);
          m_f4  = sat_inc(m_f4, 15);
        end
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int tag);
    step(tag, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s tag=%0d got=%0h expected=%0h", name, tag, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ctl", e.tag, {27'd0, pc_en, ifid_en, idex_en, ifid_flush, idex_flush}, {27'd0, e.ctl});
        chk("ctl4", e.tag, {27'd0, pc_en4, ifid_en4, idex_en4, ifid_flush4, idex_flush4}, {27'd0, e.ctl});
        chk("state", e.tag, {30'd0, state}, {30'd0, e.st});
        chk("state4", e.tag, {30'd0, state4}, {30'd0, e.st});
        chk("stall_cnt", e.tag, stall_cnt, e.s32);
        chk("flush_cnt", e.tag, flush_cnt, e.f32);
        chk("stall_cnt4", e.tag, {28'd0, stall_cnt4}, {28'd0, e.s4});
        chk("flush_cnt4", e.tag, {28'd0, flush_cnt4}, {28'd0, e.f4});
      end
    end
  end

  initial begin : stimulus
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(0);
    // Load-use on rs2: one bubble then normal.
    step(1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1, 0);
    step(1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    // ex_rd == 0 never hazards.
    step(2, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0);
    idle(2);
    // Hazard together with redirect: redirect wins.
    step(3, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0);
    idle(3);
    step(3, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    // Three busy cycles with a redirect in the middle, replayed on release.
    step(4, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(4, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(4, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(4);
    idle(4);
    // Long freeze saturates the 4-bit counter; clear while still busy.
    for (int i = 0; i < 20; i++) step(5, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(5, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    step(5, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(5);
    // Reset during MEM_WAIT with a pending redirect drops it.
    step(6, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(6, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(6, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(6, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(6);
    for (int i = 0; i < 1500; i++) begin
      step(100 + i,
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 50),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 99) < 3));
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of each performance counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 id_rs1 / id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 id_uses_rs1 / id_uses_rs2  input  1 each  ID instruction actually reads that source.
REQ-006 ex_rd  input  5  destination index held in the ID/EX register.
REQ-007 ex_MemRead  input  1  ID/EX holds a load.
REQ-008 ex_redirect  input  1  EX resolved a taken branch or jump this cycle.
REQ-009 mem_busy  input  1  data memory not ready; pipeline must freeze.
REQ-010 cnt_clr  input  1  synchronous clear of both counters.
REQ-011 pc_en, ifid_en, idex_en  output  1 each  write enables for PC, IF/ID and ID/EX registers.
REQ-012 ifid_flush, idex_flush  output  1 each  load a bubble (all control fields 0) into IF/ID or ID/EX.
REQ-013 state  output  2  current FSM state: RUN=0, LU_STALL=1, MEM_WAIT=2.
REQ-014 stall_cnt, flush_cnt  output  CNT_WIDTH each  performance counters.

Function
REQ-015 Enable/flush outputs are combinational from state, redirect_pend and inputs; state, redirect_pend and counters are registered.
REQ-016 Load-use hazard = ex_MemRead & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)); ex_rd==0 never hazards.
REQ-017 Evaluation priority each cycle: mem_busy > redirect > load-use hazard > normal.
REQ-018 FREEZE action: pc_en=ifid_en=idex_en=0, both flushes 0.
REQ-019 REDIRECT action: all enables 1, ifid_flush=1, idex_flush=1.
REQ-020 BUBBLE action: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, ifid_flush=0.
REQ-021 NORMAL action: all enables 1, both flushes 0.
REQ-022 RUN: mem_busy -> FREEZE, next MEM_WAIT, redirect_pend<=ex_redirect; else ex_redirect -> REDIRECT, stay RUN; else hazard -> BUBBLE, next LU_STALL; else NORMAL.
REQ-023 LU_STALL lasts exactly one cycle, hazard detection masked: mem_busy -> FREEZE, next MEM_WAIT; else ex_redirect -> REDIRECT; else NORMAL; next RUN when not mem_busy.
REQ-024 MEM_WAIT: while mem_busy -> FREEZE, redirect_pend<=redirect_pend|ex_redirect, stay.
REQ-025 MEM_WAIT with mem_busy=0: behave as RUN using effective redirect = ex_redirect|redirect_pend; clear redirect_pend; next RUN, or LU_STALL if BUBBLE taken.
REQ-026 A pending redirect produces exactly one REDIRECT cycle, even when ex_redirect is also high that cycle.
REQ-027 stall_cnt increments by 1 on every cycle with pc_en=0; flush_cnt increments by 1 on every REDIRECT cycle.
REQ-028 Counters saturate at all-ones, no wrap.
REQ-029 cnt_clr zeroes both counters; clr wins over simultaneous increment (counter reads 0 next cycle).

Reset
REQ-030 reset asserted: state=RUN, redirect_pend=0, stall_cnt=0, flush_cnt=0 immediately, independent of clk.
REQ-031 While reset asserted: pc_en=ifid_en=idex_en=0, ifid_flush=idex_flush=0.
REQ-032 Reset mid-MEM_WAIT discards any pending redirect; first cycle after release evaluates from RUN.

Verification
REQ-033 ex_MemRead=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 in RUN -> one BUBBLE cycle (pc_en=0, idex_flush=1), state=1 then 0, stall_cnt=1.
REQ-034 Same as REQ-033 with ex_rd=0 -> NORMAL, state stays 0, stall_cnt=0.
REQ-035 Hazard and ex_redirect together -> REDIRECT only, flush_cnt=1, stall_cnt=0, state stays 0.
REQ-036 mem_busy high 3 cycles with ex_redirect pulse in cycle 2 -> 3 FREEZE cycles, state=2, then one REDIRECT cycle on release, stall_cnt=3, flush_cnt=1.
REQ-037 CNT_WIDTH=4, hold mem_busy 20 cycles -> stall_cnt saturates at 15; cnt_clr pulse with mem_busy still high -> stall_cnt=0 next cycle.
REQ-038 Assert reset during MEM_WAIT with redirect_pend=1 -> outputs per REQ-031 at once; after release with mem_busy=0 -> NORMAL, no REDIRECT, counters 0.
